// File: rtl/countdown_timer_mmss.sv
// countdown_timer_mmss: BCD MM:SS down-counter for the kitchen/snooze timer.
// The preset is loaded with LD. The count decrements once per Tick while
// running. When the count reaches 00:00 the block raises the buzzer request.
// Ports:
//   Clk, Clr        clock, async active-low clear
//   Tick            1 Hz enable pulse, one Clk wide
//   LD, IN_*        preset load strobe and preset digits (clamped to 59:59)
//   Start, Stop     run/resume and pause/cancel levels
//   Ack             silence buzzer
//   MIN_*, SEC_*    current count digits
//   RUNNING, EXPIRED, BUZZ  registered state decodes
module countdown_timer_mmss #(
  parameter int BUZZ_TICKS = 10
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick,
  input  logic       LD,
  input  logic [2:0] IN_MIN_T,
  input  logic [3:0] IN_MIN_U,
  input  logic [2:0] IN_SEC_T,
  input  logic [3:0] IN_SEC_U,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Ack,
  output logic [2:0] MIN_T,
  output logic [3:0] MIN_U,
  output logic [2:0] SEC_T,
  output logic [3:0] SEC_U,
  output logic       RUNNING,
  output logic       EXPIRED,
  output logic       BUZZ
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPD} state_t;

  state_t     state, state_nx;
  logic [2:0] mt_nx, st_nx;
  logic [3:0] mu_nx, su_nx;
  logic [7:0] bcnt, bcnt_nx;
  logic       cnt_zero, cnt_one;

  // Preset with clamp: units cap at 9 and tens cap at 5
  logic [2:0] ld_mt, ld_st;
  logic [3:0] ld_mu, ld_su;
  assign ld_mt = (IN_MIN_T > 3'd5) ? 3'd5 : IN_MIN_T;
  assign ld_mu = (IN_MIN_U > 4'd9) ? 4'd9 : IN_MIN_U;
  assign ld_st = (IN_SEC_T > 3'd5) ? 3'd5 : IN_SEC_T;
  assign ld_su = (IN_SEC_U > 4'd9) ? 4'd9 : IN_SEC_U;

  assign cnt_zero = (MIN_T == 3'd0) && (MIN_U == 4'd0) && (SEC_T == 3'd0) && (SEC_U == 4'd0);
  assign cnt_one  = (MIN_T == 3'd0) && (MIN_U == 4'd0) && (SEC_T == 3'd0) && (SEC_U == 4'd1);

  always_comb begin
    state_nx = state;
    mt_nx    = MIN_T;
    mu_nx    = MIN_U;
    st_nx    = SEC_T;
    su_nx    = SEC_U;
    bcnt_nx  = bcnt;
    case (state)
      IDLE: begin
        if (Stop) begin
          state_nx = IDLE;
        end else if (Start && !cnt_zero) begin
          state_nx = RUN;
        end else if (LD) begin
          mt_nx = ld_mt; mu_nx = ld_mu; st_nx = ld_st; su_nx = ld_su;
        end
      end
      RUN: begin
        if (Stop) begin
          state_nx = PAUSE;
        end else if (Tick) begin
          // A Tick at 00:01 reaches 00:00 and expires on the same edge.
          // A Tick at 00:00 can only follow an LD of 00:00 in PAUSE.
          // In that case the block expires instead of wrapping.
          if (cnt_one || cnt_zero) begin
            su_nx    = 4'd0;
            state_nx = EXPD;
            bcnt_nx  = 8'd0;
          end else if (SEC_U != 4'd0) begin
            su_nx = SEC_U - 4'd1;
          end else begin
            su_nx = 4'd9;
            if (SEC_T != 3'd0) begin
              st_nx = SEC_T - 3'd1;
            end else begin
              st_nx = 3'd5;
              if (MIN_U != 4'd0) begin
                mu_nx = MIN_U - 4'd1;
              end else begin
                mu_nx = 4'd9;
                mt_nx = MIN_T - 3'd1;
              end
            end
          end
        end
      end
      PAUSE: begin
        if (Stop) begin
          state_nx = IDLE;
          mt_nx = 3'd0; mu_nx = 4'd0; st_nx = 3'd0; su_nx = 4'd0;
        end else if (Start) begin
          state_nx = RUN;
        end else if (LD) begin
          mt_nx = ld_mt; mu_nx = ld_mu; st_nx = ld_st; su_nx = ld_su;
        end
      end
      EXPD: begin
        mt_nx = 3'd0; mu_nx = 4'd0; st_nx = 3'd0; su_nx = 4'd0;
        if (Ack || Stop) begin
          state_nx = IDLE;
          bcnt_nx  = 8'd0;
        end else if (Tick) begin
          bcnt_nx = bcnt + 8'd1;
          if ((BUZZ_TICKS != 0) && (bcnt_nx == 8'(BUZZ_TICKS))) begin
            state_nx = IDLE;
            bcnt_nx  = 8'd0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        bcnt_nx  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state   <= IDLE;
      MIN_T   <= 3'd0;
      MIN_U   <= 4'd0;
      SEC_T   <= 3'd0;
      SEC_U   <= 4'd0;
      bcnt    <= 8'd0;
      RUNNING <= 1'b0;
      EXPIRED <= 1'b0;
      BUZZ    <= 1'b0;
    end else begin
      state   <= state_nx;
      MIN_T   <= mt_nx;
      MIN_U   <= mu_nx;
      SEC_T   <= st_nx;
      SEC_U   <= su_nx;
      bcnt    <= bcnt_nx;
      // The decodes come from the next state, so they line up with state.
      RUNNING <= (state_nx == RUN);
      EXPIRED <= (state_nx == EXPD);
      BUZZ    <= (state_nx == EXPD);
    end
  end

endmodule

// File: tb/tb_countdown_timer_mmss.sv
module tb_countdown_timer_mmss;
  logic       Clk, Clr, Tick, LD, Start, Stop, Ack;
  logic [2:0] IN_MIN_T, IN_SEC_T;
  logic [3:0] IN_MIN_U, IN_SEC_U;
  logic [2:0] MIN_T, SEC_T, MIN_T0, SEC_T0;
  logic [3:0] MIN_U, SEC_U, MIN_U0, SEC_U0;
  logic       RUNNING, EXPIRED, BUZZ, RUNNING0, EXPIRED0, BUZZ0;
  int nvec = 0, nerr = 0;

  countdown_timer_mmss #(.BUZZ_TICKS(3)) u_dut (
    .Clk(Clk), .Clr(Clr), .Tick(Tick), .LD(LD),
    .IN_MIN_T(IN_MIN_T), .IN_MIN_U(IN_MIN_U), .IN_SEC_T(IN_SEC_T), .IN_SEC_U(IN_SEC_U),
    .Start(Start), .Stop(Stop), .Ack(Ack),
    .MIN_T(MIN_T), .MIN_U(MIN_U), .SEC_T(SEC_T), .SEC_U(SEC_U),
    .RUNNING(RUNNING), .EXPIRED(EXPIRED), .BUZZ(BUZZ));

  countdown_timer_mmss #(.BUZZ_TICKS(0)) u_dut0 (
    .Clk(Clk), .Clr(Clr), .Tick(Tick), .LD(LD),
    .IN_MIN_T(IN_MIN_T), .IN_MIN_U(IN_MIN_U), .IN_SEC_T(IN_SEC_T), .IN_SEC_U(IN_SEC_U),
    .Start(Start), .Stop(Stop), .Ack(Ack),
    .MIN_T(MIN_T0), .MIN_U(MIN_U0), .SEC_T(SEC_T0), .SEC_U(SEC_U0),
    .RUNNING(RUNNING0), .EXPIRED(EXPIRED0), .BUZZ(BUZZ0));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compares the u_dut count against the expected MM:SS digits.
  task automatic chk_cnt(input string tag, input int mt, input int mu, input int st, input int su);
    chk(tag, {18'd0, MIN_T, MIN_U, SEC_T, SEC_U},
        {18'd0, 3'(mt), 4'(mu), 3'(st), 4'(su)});
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic load(input int mt, input int mu, input int st, input int su);
    IN_MIN_T = 3'(mt); IN_MIN_U = 4'(mu); IN_SEC_T = 3'(st); IN_SEC_U = 4'(su);
    LD = 1'b1; cyc(); LD = 1'b0;
  endtask

  task automatic pulse_start(); Start = 1'b1; cyc(); Start = 1'b0; endtask
  task automatic pulse_stop();  Stop  = 1'b1; cyc(); Stop  = 1'b0; endtask
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      Tick = 1'b1; cyc(); Tick = 1'b0;
    end
  endtask

  initial begin
    Clr = 1'b0; Tick = 0; LD = 0; Start = 0; Stop = 0; Ack = 0;
    IN_MIN_T = 0; IN_MIN_U = 0; IN_SEC_T = 0; IN_SEC_U = 0;
    #3;
    chk_cnt("reset_cnt", 0, 0, 0, 0);
    chk("reset_run", RUNNING, 0);
    chk("reset_buzz", BUZZ, 0);
    #20 Clr = 1'b1;
    cyc();

    // Clear mid-RUN at 12:34 without any clock edge.
    load(1, 2, 3, 4);
    chk_cnt("load_1234", 1, 2, 3, 4);
    pulse_start();
    chk("run_1234", RUNNING, 1);
    #2 Clr = 1'b0; #1;
    chk_cnt("clr_async_cnt", 0, 0, 0, 0);
    chk("clr_async_run", RUNNING, 0);
    #1 Clr = 1'b1;
    cyc();
    load(0, 5, 0, 9);
    chk_cnt("load_0509", 0, 5, 0, 9);

    // Tick in IDLE is ignored.
    tick();
    chk_cnt("idle_tick", 0, 5, 0, 9);

    // Borrow chain
    load(1, 0, 0, 0);
    pulse_start();
    tick();
    chk_cnt("borrow_1000", 0, 9, 5, 9);
    pulse_stop(); pulse_stop();
    chk_cnt("stop2_clear", 0, 0, 0, 0);
    load(0, 1, 0, 0);
    pulse_start();
    tick();
    chk_cnt("borrow_0100", 0, 0, 5, 9);
    pulse_stop(); pulse_stop();

    // Expiry with auto-silence after 3 ticks
    load(0, 0, 0, 2);
    pulse_start();
    tick();
    chk_cnt("exp_0001", 0, 0, 0, 1);
    tick();
    chk_cnt("exp_0000", 0, 0, 0, 0);
    chk("exp_expired", EXPIRED, 1);
    chk("exp_buzz", BUZZ, 1);
    chk("exp_running", RUNNING, 0);
    tick(2);
    chk("buzz_after2", BUZZ, 1);
    tick();
    chk("buzz_after3", BUZZ, 0);
    chk("expired_after3", EXPIRED, 0);

    // Pause with coincident Tick, resume, cancel
    load(0, 0, 3, 0);
    pulse_start();
    Stop = 1'b1; Tick = 1'b1; cyc(); Stop = 1'b0; Tick = 1'b0;
    chk_cnt("pause_hold", 0, 0, 3, 0);
    chk("pause_run", RUNNING, 0);
    Start = 1'b1; Tick = 1'b1; cyc(); Start = 1'b0; Tick = 1'b0;
    chk_cnt("resume_notick", 0, 0, 3, 0);
    chk("resume_run", RUNNING, 1);
    tick();
    chk_cnt("resume_tick", 0, 0, 2, 9);
    pulse_stop();
    load(0, 4, 0, 0);
    chk_cnt("pause_load", 0, 4, 0, 0);
    chk("pause_load_run", RUNNING, 0);
    pulse_stop();
    chk_cnt("cancel_cnt", 0, 0, 0, 0);
    pulse_start();
    chk("cancel_idle", RUNNING, 0);

    // Clamp and zero-start
    load(7, 0, 0, 12);
    chk_cnt("clamp_a", 5, 0, 0, 9);
    load(6, 11, 6, 15);
    chk_cnt("clamp_b", 5, 9, 5, 9);
    load(0, 0, 0, 0);
    pulse_start();
    chk("zero_start", RUNNING, 0);

    // BUZZ_TICKS=0 holds until Ack.
    #2 Clr = 1'b0; #2 Clr = 1'b1;
    cyc();
    load(0, 0, 0, 1);
    pulse_start();
    tick();
    chk("b0_expired", EXPIRED0, 1);
    tick(20);
    chk("b0_buzz20", BUZZ0, 1);
    chk("b0_cnt", {18'd0, MIN_T0, MIN_U0, SEC_T0, SEC_U0}, 32'd0);
    Ack = 1'b1; cyc(); Ack = 1'b0;
    chk("b0_ack_buzz", BUZZ0, 0);
    chk("b0_ack_exp", EXPIRED0, 0);

    // LD during RUN is ignored.
    load(0, 3, 0, 0);
    pulse_start();
    load(1, 1, 1, 1);
    chk_cnt("run_ld_ignored", 0, 3, 0, 0);
    chk("run_ld_running", RUNNING, 1);
    tick();
    chk_cnt("run_tick_0300", 0, 2, 5, 9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
